rf_wb_arbiter: RTL and testbench

Arbitrates the single register-file write port of the NPC core among several write-back requesters (ALU, LSU, CSR unit). Each cycle it grants at most one valid request through a valid/ready handshake, then drives one registered write (enable, address, data) into the register-file flops one cycle later. It owns all sequencing of the register-file write port; requesters never drive it directly.

---
 rtl/core_pkg.sv | 11 +
 rtl/rf_wb_arbiter_rr_pick.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 94 +++++++++
 tb/tb_rf_wb_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath/register-file widths, x0 and write-back source ids.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_CSR = 2;
endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rr_pick: combinational circular priority picker; first set request at or after
// start (ascending, wrapping) wins.
module rr_pick #(
    parameter int N  = 3,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] pos_s;
    logic          hit_s;

    // Walk the N positions from start, latching the first request seen.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_s        = SW'((32'(start) + 32'(i)) % 32'(N));
            hit_s        = !any && req[pos_s];
            grant[pos_s] = grant[pos_s] | hit_s;
            idx          = hit_s ? pos_s : idx;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: grants one write-back request per cycle and
// registers the write. Define RF_WB_ARB_RR_EN for round-robin, else fixed priority.
module rf_wb_arbiter
    import core_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = XLEN,
    parameter int AW   = REG_AW,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic             wb_wen,
    output logic [AW-1:0]    wb_addr,
    output logic [DW-1:0]    wb_data,
    output logic [SW-1:0]    wb_src
);

    logic [SW-1:0]   start_s;
    logic [NREQ-1:0] grant_s;
    logic [SW-1:0]   gidx_s;
    logic            any_s;
    logic            hs_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;

`ifdef RF_WB_ARB_RR_EN
    logic [SW-1:0] ptr_r;
    logic [SW-1:0] ptr_nxt_s;

    assign start_s   = ptr_r;
    assign ptr_nxt_s = (gidx_s == SW'(NREQ - 1)) ? SW'(0) : gidx_s + SW'(1);

    // Priority pointer: advance past the winner on every handshake, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= ptr_nxt_s;
        end
    end
`else
    assign start_s = '0;
`endif

    rr_pick #(.N(NREQ), .SW(SW)) u_pick (
        .req   (req_valid),
        .start (start_s),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (any_s)
    );

    // Grant gating: flush and reset suppress every grant in the same cycle.
    always_comb begin
        if (rst || flush) begin
            req_ready = '0;
            hs_s      = 1'b0;
        end else begin
            req_ready = grant_s;
            hs_s      = any_s;
        end
        sel_addr_s = req_addr[gidx_s*AW +: AW];
        sel_data_s = req_data[gidx_s*DW +: DW];
    end

    // Output stage payload: captured on handshake, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else if (hs_s) begin
            wb_addr <= sel_addr_s;
            wb_data <= sel_data_s;
            wb_src  <= gidx_s;
        end
    end

    // Write enable is a one-cycle pulse; x0 writes handshake but are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wen <= 1'b0;
        end else begin
            wb_wen <= hs_s && (sel_addr_s != AW'(REG_ZERO));
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter; expectations follow RF_WB_ARB_RR_EN when defined.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SW   = 2;
    localparam int NV   = 23;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic             wb_wen;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic [SW-1:0]    wb_src;

    int n_vec = 0;
    int n_bad = 0;
    logic rr;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic        cw;
        logic [2:0]  rdy;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ws;
    } vec_t;

    vec_t tbl [NV];

    rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wb_wen    (wb_wen),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_src    (wb_src)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic [2:0] val,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic cw, input logic [2:0] rdy, input logic wen,
                                input logic [4:0] wa, input logic [31:0] wd, input logic [1:0] ws);
        vec_t v;
        v.rst = r; v.flush = f; v.valid = val;
        v.addr = {a2, a1, a0};
        v.data = {d2, d1, d0};
        v.cw = cw; v.rdy = rdy; v.wen = wen; v.wa = wa; v.wd = wd; v.ws = ws;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [2:0] val,
                         input logic [14:0] a, input logic [95:0] d);
        rst = r; flush = f; req_valid = val; req_addr = a; req_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
`ifdef RF_WB_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // reset with all requests valid
        tbl[0]  = mk(1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[1]  = mk(1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[2]  = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
        // single write from requester 1
        tbl[3]  = mk(1'b0, 1'b0, 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[4]  = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
        // x0 drop from requester 2
        tbl[5]  = mk(1'b0, 1'b0, 3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234, 1'b1, 3'b100, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);
        tbl[6]  = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd2);
        // contention, six cycles
        tbl[7]  = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, 3'b001, 1'b0, 5'd0, 32'h1234, 2'd2);
        tbl[8]  = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, rr ? 3'b010 : 3'b001, 1'b1, 5'd1, 32'h100, 2'd0);
        tbl[9]  = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, rr ? 3'b100 : 3'b001, 1'b1,
                     rr ? 5'd2 : 5'd1, rr ? 32'h200 : 32'h100, rr ? 2'd1 : 2'd0);
        tbl[10] = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, 3'b001, 1'b1,
                     rr ? 5'd3 : 5'd1, rr ? 32'h300 : 32'h100, rr ? 2'd2 : 2'd0);
        tbl[11] = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, rr ? 3'b010 : 3'b001, 1'b1, 5'd1, 32'h100, 2'd0);
        tbl[12] = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, rr ? 3'b100 : 3'b001, 1'b1,
                     rr ? 5'd2 : 5'd1, rr ? 32'h200 : 32'h100, rr ? 2'd1 : 2'd0);
        tbl[13] = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b1,
                     rr ? 5'd3 : 5'd1, rr ? 32'h300 : 32'h100, rr ? 2'd2 : 2'd0);
        // requester 0 moves ptr to 1, then flush
        tbl[14] = mk(1'b0, 1'b0, 3'b001, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h0, 1'b1, 3'b001, 1'b0,
                     rr ? 5'd3 : 5'd1, rr ? 32'h300 : 32'h100, rr ? 2'd2 : 2'd0);
        tbl[15] = mk(1'b0, 1'b1, 3'b011, 5'd1, 5'd2, 5'd0, 32'h100, 32'h200, 32'h0, 1'b1, 3'b000, 1'b1, 5'd1, 32'h100, 2'd0);
        tbl[16] = mk(1'b0, 1'b0, 3'b011, 5'd1, 5'd2, 5'd0, 32'h100, 32'h200, 32'h0, 1'b1, rr ? 3'b010 : 3'b001, 1'b0, 5'd1, 32'h100, 2'd0);
        tbl[17] = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b1,
                     rr ? 5'd2 : 5'd1, rr ? 32'h200 : 32'h100, rr ? 2'd1 : 2'd0);
        // handshake then reset mid-stream
        tbl[18] = mk(1'b0, 1'b0, 3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h777, 32'h0, 1'b1, 3'b010, 1'b0,
                     rr ? 5'd2 : 5'd1, rr ? 32'h200 : 32'h100, rr ? 2'd1 : 2'd0);
        tbl[19] = mk(1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, 3'b000, 1'b1, 5'd7, 32'h777, 2'd1);
        tbl[20] = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[21] = mk(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[22] = mk(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b1, 5'd1, 32'h100, 2'd0);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].flush, tbl[k].valid, tbl[k].addr, tbl[k].data);
            #1;
            chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
            if (tbl[k].cw) begin
                chk($sformatf("v%0d_wen", k), 32'(wb_wen), 32'(tbl[k].wen));
                chk($sformatf("v%0d_addr", k), 32'(wb_addr), 32'(tbl[k].wa));
                chk($sformatf("v%0d_data", k), wb_data, tbl[k].wd);
                chk($sformatf("v%0d_src", k), 32'(wb_src), 32'(tbl[k].ws));
            end
        end

        // back-to-back handshakes by the same requester
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h900, 64'h0});
        #1 chk("b2b_ready0", 32'(req_ready), 32'h4);
        @(negedge clk);
        #1 chk("b2b_ready1", 32'(req_ready), 32'h4);
        chk("b2b_wen1", 32'(wb_wen), 32'h1);
        chk("b2b_addr1", 32'(wb_addr), 32'h9);
        chk("b2b_src1", 32'(wb_src), 32'h2);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 15'h0, 96'h0);
        #1 chk("b2b_wen2", 32'(wb_wen), 32'h1);
        chk("b2b_data2", wb_data, 32'h900);
        @(negedge clk);
        #1 chk("b2b_wen3", 32'(wb_wen), 32'h0);
        chk("b2b_addr3", 32'(wb_addr), 32'h9);

`ifdef RF_WB_ARB_RR_EN
        // fairness: requester 2 held valid must be granted within NREQ cycles
        found = 1'b0;
        for (int c = 0; c < NREQ && !found; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h300, 32'h200, 32'h100});
            #1 found = req_ready[2];
        end
        chk("fair_grant2", 32'(found), 32'h1);
`else
        found = 1'b0;
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 15'h0, 96'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
